// File: rtl/matmul_seq_ctrl_if.sv
// Handshake, SRAM and MAC bus between the matrix-multiply sequencer and its environment.
// The sequencer masters the SRAM/MAC side; the environment (SRAMs, MAC, host) is the slave.
interface matmul_seq_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              dut_valid;
  logic              dut_ready;
  logic [ADDR_W-1:0] dut__tb__sram_input_read_address;
  logic [DATA_W-1:0] tb__dut__sram_input_read_data;
  logic [ADDR_W-1:0] dut__tb__sram_weight_read_address;
  logic [DATA_W-1:0] tb__dut__sram_weight_read_data;
  logic              dut__tb__sram_result_write_enable;
  logic [ADDR_W-1:0] dut__tb__sram_result_write_address;
  logic [DATA_W-1:0] dut__tb__sram_result_write_data;
  logic              mac_valid;
  logic              mac_first;
  logic              mac_last;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_done;
  logic [DATA_W-1:0] mac_result;

  modport master (
    input  dut_valid,
    output dut_ready,
    output dut__tb__sram_input_read_address,
    input  tb__dut__sram_input_read_data,
    output dut__tb__sram_weight_read_address,
    input  tb__dut__sram_weight_read_data,
    output dut__tb__sram_result_write_enable,
    output dut__tb__sram_result_write_address,
    output dut__tb__sram_result_write_data,
    output mac_valid,
    output mac_first,
    output mac_last,
    output mac_a,
    output mac_b,
    input  mac_done,
    input  mac_result
  );

  modport slave (
    output dut_valid,
    input  dut_ready,
    input  dut__tb__sram_input_read_address,
    output tb__dut__sram_input_read_data,
    input  dut__tb__sram_weight_read_address,
    output tb__dut__sram_weight_read_data,
    input  dut__tb__sram_result_write_enable,
    input  dut__tb__sram_result_write_address,
    input  dut__tb__sram_result_write_data,
    input  mac_valid,
    input  mac_first,
    input  mac_last,
    input  mac_a,
    input  mac_b,
    output mac_done,
    output mac_result
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B: reads dimension headers, walks i/j/k with running-adder
// address generation, streams operand beats to an external MAC and writes C row-major.
module matmul_seq_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  matmul_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, HDR, HDR_CAP, ISSUE, WAIT_MAC, WRITE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] m_dim, k_dim, n_dim;
  logic [ADDR_W-1:0] i_cnt, j_cnt, k_cnt;
  logic [ADDR_W-1:0] a_base, b_base;
  logic [ADDR_W-1:0] in_addr, wt_addr, res_addr;
  logic [DATA_W-1:0] result;
  logic              beat_valid, beat_first, beat_last;
  logic              last_k, last_j, last_i, hdr_zero;
  logic [ADDR_W-1:0] hdr_m, hdr_k, hdr_n;

  assign hdr_m    = ADDR_W'(bus.tb__dut__sram_input_read_data[2*DIM_W-1:DIM_W]);
  assign hdr_k    = ADDR_W'(bus.tb__dut__sram_input_read_data[DIM_W-1:0]);
  assign hdr_n    = ADDR_W'(bus.tb__dut__sram_weight_read_data[DIM_W-1:0]);
  assign hdr_zero = (hdr_m == '0) || (hdr_k == '0) || (hdr_n == '0);

  assign last_k = (k_cnt == k_dim - ONE);
  assign last_j = (j_cnt == n_dim - ONE);
  assign last_i = (i_cnt == m_dim - ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.dut_valid) next_state = HDR;
      HDR:      next_state = HDR_CAP;
      HDR_CAP:  next_state = hdr_zero ? IDLE : ISSUE;
      ISSUE:    if (last_k) next_state = WAIT_MAC;
      WAIT_MAC: if (bus.mac_done) next_state = WRITE;
      WRITE:    next_state = (last_i && last_j) ? IDLE : ISSUE;
      default:  next_state = IDLE;
    endcase
  end

  // Addresses are registered and always hold the beat being issued; at each WRITE
  // they are preloaded with the first beat of the next element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dim <= '0; k_dim <= '0; n_dim <= '0;
      i_cnt <= '0; j_cnt <= '0; k_cnt <= '0;
      a_base <= '0; b_base <= '0;
      in_addr <= '0; wt_addr <= '0; res_addr <= '0;
      result <= '0;
      beat_valid <= 1'b0; beat_first <= 1'b0; beat_last <= 1'b0;
    end else begin
      beat_valid <= (state == ISSUE);
      beat_first <= (state == ISSUE) && (k_cnt == '0);
      beat_last  <= (state == ISSUE) && last_k;
      case (state)
        IDLE: begin
          if (bus.dut_valid) begin
            in_addr <= '0;
            wt_addr <= '0;
          end
        end
        HDR_CAP: begin
          m_dim <= hdr_m; k_dim <= hdr_k; n_dim <= hdr_n;
          i_cnt <= '0; j_cnt <= '0; k_cnt <= '0;
          a_base <= ONE; b_base <= ONE;
          in_addr <= ONE; wt_addr <= ONE;
          res_addr <= '0;
        end
        ISSUE: begin
          if (last_k) begin
            k_cnt <= '0;
          end else begin
            k_cnt   <= k_cnt + ONE;
            in_addr <= in_addr + ONE;
            wt_addr <= wt_addr + n_dim;
          end
        end
        WAIT_MAC: begin
          if (bus.mac_done) result <= bus.mac_result;
        end
        WRITE: begin
          res_addr <= res_addr + ONE;
          if (last_j) begin
            j_cnt   <= '0;
            i_cnt   <= i_cnt + ONE;
            a_base  <= a_base + k_dim;
            b_base  <= ONE;
            in_addr <= a_base + k_dim;
            wt_addr <= ONE;
          end else begin
            j_cnt   <= j_cnt + ONE;
            b_base  <= b_base + ONE;
            in_addr <= a_base;
            wt_addr <= b_base + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_ready                          = (state == IDLE);
  assign bus.dut__tb__sram_input_read_address   = in_addr;
  assign bus.dut__tb__sram_weight_read_address  = wt_addr;
  assign bus.dut__tb__sram_result_write_enable  = (state == WRITE);
  assign bus.dut__tb__sram_result_write_address = res_addr;
  assign bus.dut__tb__sram_result_write_data    = result;
  assign bus.mac_valid                          = beat_valid;
  assign bus.mac_first                          = beat_first;
  assign bus.mac_last                           = beat_last;
  assign bus.mac_a                              = bus.tb__dut__sram_input_read_data;
  assign bus.mac_b                              = bus.tb__dut__sram_weight_read_data;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: SRAM and MAC models, expected writes queued
// at stimulus time and popped by an independent result-write monitor.
module tb_matmul_seq_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   writes = 0;
  int   beats = 0;
  int   fl_beats = 0;
  int   mac_delay = 1;
  wr_t  sb[$];

  logic [31:0] input_mem [0:63];
  logic [31:0] weight_mem[0:63];

  matmul_seq_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus();

  matmul_seq_ctrl #(.ADDR_W(16), .DATA_W(32), .DIM_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int fp2int(input logic [31:0] f);
    int e;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    return int'({1'b1, f[22:0]}) >> (23 - e);
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int p;
    logic [31:0] t;
    if (v == 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    t = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), t[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // SRAMs return the data of the previous cycle's address.
  always @(posedge clk) begin
    bus.tb__dut__sram_input_read_data  <= input_mem[bus.dut__tb__sram_input_read_address[5:0]];
    bus.tb__dut__sram_weight_read_data <= weight_mem[bus.dut__tb__sram_weight_read_address[5:0]];
  end

  int  acc;
  logic pending;
  int  cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= 0; pending <= 1'b0; cnt <= 0;
      bus.mac_done <= 1'b0; bus.mac_result <= 32'd0;
    end else begin
      bus.mac_done <= 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          bus.mac_done   <= 1'b1;
          bus.mac_result <= int2fp(acc);
          pending        <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (bus.mac_valid) begin
        beats <= beats + 1;
        if (bus.mac_first && bus.mac_last) fl_beats <= fl_beats + 1;
        acc <= (bus.mac_first ? 0 : acc) + fp2int(bus.mac_a) * fp2int(bus.mac_b);
        if (bus.mac_last) begin
          pending <= 1'b1;
          cnt     <= mac_delay;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.dut__tb__sram_result_write_enable) begin
      wr_t e;
      writes++;
      checkOutput("ready_during_write", {31'd0, bus.dut_ready}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", {16'd0, bus.dut__tb__sram_result_write_address}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", {16'd0, bus.dut__tb__sram_result_write_address}, {16'd0, e.addr});
        checkOutput("wr_data", bus.dut__tb__sram_result_write_data, e.data);
      end
    end
  end

  task automatic expectWrite(input logic [15:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  task automatic loadHeader(input int m, input int k, input int n);
    input_mem[0]  = {16'(m), 16'(k)};
    weight_mem[0] = {16'(k), 16'(n)};
  endtask

  task automatic applyStimulus();
    @(negedge clk) bus.dut_valid = 1'b1;
    @(negedge clk) bus.dut_valid = 1'b0;
  endtask

  task automatic waitReady(input string name, input int budget);
    int n = 0;
    while (!bus.dut_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, bus.dut_ready}, 32'd1);
  endtask

  task automatic waitBusy(input string name, input int budget);
    int n = 0;
    while (bus.dut_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, bus.dut_ready}, 32'd0);
  endtask

  task automatic waitBeat(input string name, input int budget);
    int n = 0;
    while (!bus.mac_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, bus.mac_valid}, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, bus.dut_ready}, 32'd1);
    checkOutput({tag, "_in_addr"}, {16'd0, bus.dut__tb__sram_input_read_address}, 32'd0);
    checkOutput({tag, "_wt_addr"}, {16'd0, bus.dut__tb__sram_weight_read_address}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, bus.dut__tb__sram_result_write_enable}, 32'd0);
    checkOutput({tag, "_wr_addr"}, {16'd0, bus.dut__tb__sram_result_write_address}, 32'd0);
    checkOutput({tag, "_wr_data"}, bus.dut__tb__sram_result_write_data, 32'd0);
    checkOutput({tag, "_mac_valid"}, {29'd0, bus.mac_valid, bus.mac_first, bus.mac_last}, 32'd0);
  endtask

  // 3x4 A times 4x2 B, used by the held-valid and reset-abort runs.
  task automatic load342();
    int a[12] = '{1,0,0,0, 0,1,1,0, 1,1,1,1};
    int b[8]  = '{1,2, 3,4, 1,0, 0,1};
    loadHeader(3, 4, 2);
    for (int x = 0; x < 12; x++) input_mem[1+x] = int2fp(a[x]);
    for (int x = 0; x < 8; x++)  weight_mem[1+x] = int2fp(b[x]);
  endtask

  task automatic expect342();
    expectWrite(16'd0, 32'h3F80_0000);
    expectWrite(16'd1, 32'h4000_0000);
    expectWrite(16'd2, 32'h4080_0000);
    expectWrite(16'd3, 32'h4080_0000);
    expectWrite(16'd4, 32'h40A0_0000);
    expectWrite(16'd5, 32'h40E0_0000);
  endtask

  initial begin
    int w0, b0;
    logic [15:0] ia, wa;
    bus.dut_valid = 1'b0;
    for (int x = 0; x < 64; x++) begin
      input_mem[x] = 32'd0;
      weight_mem[x] = 32'd0;
    end
    #12;
    checkResetState("reset");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] 2x2 identity times [[1,2],[3,4]]");
    loadHeader(2, 2, 2);
    input_mem[1] = int2fp(1); input_mem[2] = int2fp(0);
    input_mem[3] = int2fp(0); input_mem[4] = int2fp(1);
    for (int x = 0; x < 4; x++) weight_mem[1+x] = int2fp(x + 1);
    expectWrite(16'd0, 32'h3F80_0000);
    expectWrite(16'd1, 32'h4000_0000);
    expectWrite(16'd2, 32'h4040_0000);
    expectWrite(16'd3, 32'h4080_0000);
    w0 = writes;
    applyStimulus();
    checkOutput("busy_after_start", {31'd0, bus.dut_ready}, 32'd0);
    waitReady("t1_done", 100);
    checkOutput("t1_writes", 32'(writes - w0), 32'd4);
    checkOutput("t1_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] 1x1x1: 2.0 * 3.0");
    loadHeader(1, 1, 1);
    input_mem[1] = 32'h4000_0000; weight_mem[1] = 32'h4040_0000;
    expectWrite(16'd0, 32'h40C0_0000);
    b0 = beats; w0 = fl_beats;
    applyStimulus();
    waitReady("t2_done", 50);
    checkOutput("t2_beats", 32'(beats - b0), 32'd1);
    checkOutput("t2_first_last", 32'(fl_beats - w0), 32'd1);
    checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] K=0 header");
    loadHeader(2, 0, 2);
    b0 = beats; w0 = writes;
    applyStimulus();
    waitReady("t3_ready_within_4", 4);
    repeat (3) @(negedge clk);
    checkOutput("t3_beats", 32'(beats - b0), 32'd0);
    checkOutput("t3_writes", 32'(writes - w0), 32'd0);

    $display("[TB] slow MAC stall");
    loadHeader(1, 1, 1);
    input_mem[1] = int2fp(2); weight_mem[1] = int2fp(2);
    expectWrite(16'd0, 32'h4080_0000);
    mac_delay = 20;
    w0 = writes;
    applyStimulus();
    waitBeat("t4_beat", 10);
    ia = bus.dut__tb__sram_input_read_address;
    wa = bus.dut__tb__sram_weight_read_address;
    checkOutput("t4_in_addr_last", {16'd0, ia}, 32'd1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput("t4_stall_we", {31'd0, bus.dut__tb__sram_result_write_enable}, 32'd0);
      checkOutput("t4_stall_in_addr", {16'd0, bus.dut__tb__sram_input_read_address}, {16'd0, ia});
      checkOutput("t4_stall_wt_addr", {16'd0, bus.dut__tb__sram_weight_read_address}, {16'd0, wa});
    end
    waitReady("t4_done", 40);
    checkOutput("t4_writes", 32'(writes - w0), 32'd1);
    mac_delay = 1;

    $display("[TB] 3x4x2 with dut_valid held high");
    load342();
    expect342();
    expect342();
    w0 = writes;
    @(negedge clk) bus.dut_valid = 1'b1;
    waitBusy("t5_start", 3);
    waitReady("t5_done", 200);
    checkOutput("t5_writes", 32'(writes - w0), 32'd6);
    waitBusy("t5_restart", 2);
    bus.dut_valid = 1'b0;
    waitReady("t5_done2", 200);
    checkOutput("t5_writes2", 32'(writes - w0), 32'd12);
    checkOutput("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] reset mid-ISSUE then fresh run");
    w0 = writes;
    applyStimulus();
    waitBeat("t6_beat", 10);
    #2 reset_n = 1'b0;
    #1 checkResetState("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_no_writes", 32'(writes - w0), 32'd0);
    expect342();
    applyStimulus();
    waitReady("t6_done", 200);
    checkOutput("t6_writes", 32'(writes - w0), 32'd6);
    checkOutput("t6_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
